mux_4to1_rr: RTL and testbench
==============================

MUX_4TO1_RR -- requirements
Module: mux_4to1_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width of every lane and of the output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 x0, x1, x2, x3  input  WIDTH each  lane data.
REQ-005 v  input  4  lane valid; bit k qualifies xk.
REQ-006 rdy  output  4  lane ready; bit k high = xk is taken this cycle.
REQ-007 y  output  WIDTH  registered output data.
REQ-008 y_valid  output  1  y holds a beat.
REQ-009 y_ready  input  1  downstream accepts y.
REQ-010 s  output  2  source lane of y, using the demux select encoding (0..3 = x0..x3).

Function
REQ-011 Each port pair (v/rdy, y_valid/y_ready) SHALL transfer exactly when both signals are high on a rising edge.
REQ-012 load = (!y_valid || y_ready) && (v != 0); at most one rdy bit SHALL be high, and only when load is true.
REQ-013 Grant SHALL be round-robin: search starts at lane ptr+1 mod 4 and wraps 3 -> 0; the first lane with v set wins.
REQ-014 On load, y <= x[grant], s <= grant, y_valid <= 1, and ptr <= grant.
REQ-015 If y_valid && y_ready && !load, y_valid SHALL clear next cycle; y and s SHALL hold their values.
REQ-016 If y_valid && !y_ready, y, s and y_valid SHALL hold, and rdy SHALL be 0.
REQ-017 Latency from lane transfer to y_valid is 1 cycle; sustained throughput is 1 beat per cycle when y_ready is held high.
REQ-018 rdy SHALL depend combinationally on v, y_valid and y_ready; y_valid SHALL NOT depend on y_ready within the same cycle.
REQ-019 A lane holding v high SHALL be granted within 4 output transfers (no starvation).

Reset
REQ-020 Asserting rst_n low SHALL immediately force y_valid = 0, y = 0, s = 0, ptr = 3 (lane 0 has first priority), rdy = 0.
REQ-021 Reset during a stalled beat SHALL discard that beat; after release, arbitration restarts from lane 0.

Configuration
REQ-022 Macro MUX4_PACKET_LOCK_EN, when defined, SHALL add input x_last [3:0]; a granted beat with x_last[grant] = 0 locks the grant to that lane.
REQ-023 While locked, only the locked lane SHALL be eligible; the lock SHALL release after a transfer with x_last set. Reset clears the lock.
REQ-024 Without MUX4_PACKET_LOCK_EN, x_last SHALL NOT exist, and every beat re-arbitrates per REQ-013.

Structure
REQ-025 Package mux4_pkg SHALL hold NUM_LANES = 4, the default WIDTH, and typedef sel_t (2-bit lane index), shared with demux_4to1_slice users.
REQ-026 Grant logic SHALL live in sub-module rr_arbiter4 (inputs: req[3:0], ptr, lock; outputs: grant, any); the datapath register stays in mux_4to1_rr.

Verification
REQ-027 Reset: hold rst_n low, then release -> y_valid = 0, s = 0, y = 0, rdy = 0.
REQ-028 Single lane: v = 0100, x2 = 8'hA5, y_ready = 1 -> rdy = 0100 for one cycle; next cycle y = 8'hA5, s = 2, y_valid = 1.
REQ-029 All lanes: v = 1111 for 8 cycles with y_ready = 1 -> s sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
REQ-030 Back-pressure: y_ready = 0 with v = 0011 -> y and s hold for 5 cycles with rdy = 0; after y_ready = 1, the next s = 1.
REQ-031 Wrap/starvation: lane 3 continuously valid, lanes 0 and 1 toggling -> lane 3 is granted at least once every 4 transfers.
REQ-032 With MUX4_PACKET_LOCK_EN: lane 1 sends 3 beats, last on the third, while v = 1111 -> s = 1,1,1, then 2.

Source files
------------

// File: rtl/mux4_pkg.sv
// Shared definitions for the 4-lane mux/demux slice: lane count, default width,
// the 2-bit lane index type and a wrap-around lane helper.
package mux4_pkg;

  localparam int NUM_LANES     = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] sel_t;

  // Pointer value that gives lane 0 first priority after reset.
  localparam sel_t RESET_PTR = 2'd3;

  function automatic sel_t lane_after(input sel_t base, input int unsigned step);
    return sel_t'((32'(base) + step) % NUM_LANES);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant: searches from ptr+1 with wrap, or, while lock is
// high, only the lane ptr names is eligible.
module rr_arbiter4
  import mux4_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  sel_t                 ptr,
  input  logic                 lock,
  output sel_t                 grant,
  output logic                 any
);

  always_comb begin
    grant = ptr;
    any   = 1'b0;
    if (lock) begin
      any = req[ptr];
    end else begin
      for (int unsigned k = 1; k <= NUM_LANES; k++) begin
        if (!any && req[lane_after(ptr, k)]) begin
          any   = 1'b1;
          grant = lane_after(ptr, k);
        end
      end
    end
  end

endmodule

// File: rtl/mux_4to1_rr.sv
// Round-robin 4:1 mux with a one-deep registered output stage.
// Optional MUX4_PACKET_LOCK_EN adds x_last and holds the grant for a whole packet.
module mux_4to1_rr
  import mux4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     x0,
  input  logic [WIDTH-1:0]     x1,
  input  logic [WIDTH-1:0]     x2,
  input  logic [WIDTH-1:0]     x3,
  input  logic [NUM_LANES-1:0] v,
`ifdef MUX4_PACKET_LOCK_EN
  input  logic [NUM_LANES-1:0] x_last,
`endif
  output logic [NUM_LANES-1:0] rdy,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output sel_t                 s
);

  logic [WIDTH-1:0] lanes [NUM_LANES];
  sel_t             ptr;
  sel_t             grant;
  logic             any;
  logic             load;
  logic             lock_req;

  assign lanes[0] = x0;
  assign lanes[1] = x1;
  assign lanes[2] = x2;
  assign lanes[3] = x3;

`ifdef MUX4_PACKET_LOCK_EN
  logic locked;

  // A beat without x_last keeps the grant pinned to its lane for the next beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (load) begin
      locked <= !x_last[grant];
    end
  end

  assign lock_req = locked;
`else
  assign lock_req = 1'b0;
`endif

  rr_arbiter4 u_arb (
    .req   (v),
    .ptr   (ptr),
    .lock  (lock_req),
    .grant (grant),
    .any   (any)
  );

  // The output stage can take a new beat when empty or when it is draining.
  assign load = (!y_valid || y_ready) && any;

  always_comb begin
    rdy = '0;
    if (load) begin
      rdy[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      s       <= '0;
      y_valid <= 1'b0;
      ptr     <= RESET_PTR;
    end else if (load) begin
      y       <= lanes[grant];
      s       <= grant;
      y_valid <= 1'b1;
      ptr     <= grant;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Self-checking bench for mux_4to1_rr: directed scenarios plus randomized traffic
// against a behavioural model; honours MUX4_PACKET_LOCK_EN when defined.
module tb_mux_4to1_rr;

`ifdef MUX4_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic [3:0] v = '0;
  logic [3:0] x_last = '1;
  logic [3:0] rdy;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready = 1'b0;
  logic [1:0] s;

  int checkCount = 0;
  int failCount  = 0;

  // Behavioural model state
  int         mPtr;
  bit         mValid;
  logic [7:0] mY;
  int         mS;
  bit         mLock;
  logic [3:0] lastRdy;

  always #5 clk = ~clk;

  mux_4to1_rr #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .v       (v),
`ifdef MUX4_PACKET_LOCK_EN
    .x_last  (x_last),
`endif
    .rdy     (rdy),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .s       (s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPtr   = 3;
    mValid = 1'b0;
    mY     = '0;
    mS     = 0;
    mLock  = 1'b0;
  endtask

  // Assert reset mid-cycle, confirm the asynchronous clear, release on a negedge.
  task automatic doReset();
    @(negedge clk);
    v       = '0;
    y_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_y_valid", y_valid, 0);
    checkOutput("rst_y", y, 0);
    checkOutput("rst_s", s, 0);
    checkOutput("rst_rdy", rdy, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check against the model, then advance the model.
  task automatic applyStimulus(input logic [3:0] vIn, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3, input logic yr,
                               input logic [3:0] lastIn);
    logic [7:0] xs [4];
    int  g;
    bit  mLoad;
    logic [3:0] expRdy;
    @(negedge clk);
    v = vIn; x0 = d0; x1 = d1; x2 = d2; x3 = d3; y_ready = yr; x_last = lastIn;
    xs[0] = d0; xs[1] = d1; xs[2] = d2; xs[3] = d3;
    #1;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      int lane;
      lane = (mPtr + k) % 4;
      if (g < 0 && vIn[lane] && (!mLock || lane == mPtr)) g = lane;
    end
    mLoad  = (!mValid || yr) && (g >= 0);
    expRdy = mLoad ? 4'(1 << g) : 4'b0000;
    lastRdy = rdy;
    checkOutput("rdy", rdy, expRdy);
    checkOutput("y_valid", y_valid, mValid);
    checkOutput("y", y, mY);
    checkOutput("s", s, mS);
    @(posedge clk);
    if (mLoad) begin
      mY     = xs[g];
      mS     = g;
      mValid = 1'b1;
      mPtr   = g;
      mLock  = LOCK_EN && !lastIn[g];
    end else if (mValid && yr) begin
      mValid = 1'b0;
    end
  endtask

  initial begin
    int sgap;
    logic [7:0] heldY;
    modelReset();
    #12;
    rst_n = 1'b1;
    $display("[TB] reset state");
    doReset();
    @(negedge clk);
    checkOutput("post_rst_y_valid", y_valid, 0);
    checkOutput("post_rst_rdy", rdy, 0);

    $display("[TB] single lane");
    applyStimulus(4'b0100, 8'h11, 8'h22, 8'hA5, 8'h33, 1'b1, 4'hF);
    checkOutput("single_rdy", lastRdy, 4'b0100);
    #1;
    checkOutput("single_y", y, 8'hA5);
    checkOutput("single_s", s, 2);
    checkOutput("single_valid", y_valid, 1);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'hF);
    checkOutput("single_rdy_off", lastRdy, 4'b0000);

    $display("[TB] all lanes");
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 4'hF);
      #1 checkOutput("rr_seq", s, i % 4);
    end

    $display("[TB] back-pressure");
    doReset();
    applyStimulus(4'b0011, 8'hC0, 8'hC1, 8'h00, 8'h00, 1'b0, 4'hF);
    #1 heldY = y;
    checkOutput("bp_first_y", heldY, 8'hC0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011, 8'($urandom), 8'hC1, 8'h00, 8'h00, 1'b0, 4'hF);
      checkOutput("bp_rdy", lastRdy, 0);
      #1;
      checkOutput("bp_hold_y", y, heldY);
      checkOutput("bp_hold_s", s, 0);
    end
    applyStimulus(4'b0011, 8'hC0, 8'hC1, 8'h00, 8'h00, 1'b1, 4'hF);
    #1 checkOutput("bp_next_s", s, 1);

    $display("[TB] reset during stall");
    applyStimulus(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 4'hF);
    doReset();
    applyStimulus(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 4'hF);
    #1 checkOutput("stall_rst_restart_s", s, 0);

    $display("[TB] starvation");
    doReset();
    sgap = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus({1'b1, 1'b0, 2'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 1'($urandom_range(0, 3) != 0), 4'hF);
      if (lastRdy != 0) begin
        if (lastRdy[3]) sgap = 0;
        else sgap++;
        checkOutput("starve_gap", 32'(sgap > 3), 0);
      end
    end

`ifdef MUX4_PACKET_LOCK_EN
    $display("[TB] packet lock");
    doReset();
    applyStimulus(4'b0001, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'hF);
    applyStimulus(4'b1111, 8'h00, 8'h10, 8'h20, 8'h30, 1'b1, 4'b1101);
    #1 checkOutput("lock_s0", s, 1);
    applyStimulus(4'b1111, 8'h00, 8'h11, 8'h20, 8'h30, 1'b1, 4'b1101);
    #1 checkOutput("lock_s1", s, 1);
    applyStimulus(4'b1111, 8'h00, 8'h12, 8'h20, 8'h30, 1'b1, 4'b1111);
    #1 checkOutput("lock_s2", s, 1);
    applyStimulus(4'b1111, 8'h00, 8'h13, 8'h20, 8'h30, 1'b1, 4'b1111);
    #1 checkOutput("lock_release_s", s, 2);
`endif

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 2) != 0), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
